des_key_shift_scheduler: RTL and testbench
==========================================

// Module: des_key_shift_scheduler
// PURPOSE
//  Sequential DES key-schedule shifter. It sits directly upstream of the 56->48 compression permutation (PC-2).
//  It loads the 56-bit post-PC-1 key and splits it into halves C/D. It then emits the 16 per-round rotated
//  56-bit keys C_r||D_r, one per accepted handshake.
//  The encrypt and decrypt rotation orders are both supported, so the round engine can take keys in either order.
// PARAMETERS
//  SHIFT_SCHEDULE  16'h7EFC  bit r-1 = 1: round r rotates by 2, else by 1 (encrypt order); total must equal 28
// PORTS
//  i_clk          in   1   clock; all logic on rising edge
//  i_rst          in   1   synchronous reset, active-high
//  i_start        in   1   load request; sampled only in IDLE
//  i_key          in   56  post-PC-1 key; bit 0 = DES bit 1; C = [27:0], D = [55:28]
//  i_decrypt      in   1   0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with i_start
//  i_ready        in   1   downstream accepts o_round_key this cycle
//  o_busy         out  1   high from the cycle after accepted start until last handshake completes
//  o_valid        out  1   o_round_key/o_round valid
//  o_round_key    out  56  rotated key C_r||D_r, same bit order as i_key (feeds PC-2 i_key)
//  o_round        out  4   index of key presented, 0..15 in emission order
//  o_last         out  1   high with o_valid on o_round==15
// BEHAVIOUR
//  - One clock, i_clk. Reset is synchronous and active-high on i_rst.
//  - Reset (asserted in any state, including mid-sequence): state=IDLE; o_busy=0; o_valid=0; o_last=0;
//    o_round=0; o_round_key=0. Any in-flight sequence is discarded without completion.
//  - Rotate left by 1 on a 28-bit half h: h'[k] = h[k+1] for k = 0..26, and h'[27] = h[0].
//    Rotate by 2 = two such steps. Rotate right is the exact inverse. C and D rotate identically and never mix.
//  - FSM IDLE:
//    - i_start=1 loads the C/D registers and captures the mode.
//    - Next cycle: state=RUN, o_busy=1, o_valid=1, o_round=0.
//    - o_round_key for round 0:
//      - encrypt: i_key rotated left by SHIFT_SCHEDULE[0] amount.
//      - decrypt: i_key unrotated (C16D16 = C0D0).
//    - Latency from start to first valid: 1 cycle.
//  - FSM RUN:
//    - Outputs are held stable while o_valid && !i_ready.
//    - On o_valid && i_ready with o_round = n < 15: next cycle o_round = n+1, and the key is rotated:
//      - encrypt: left by shift(n+2), where shift(r) = 2 if SHIFT_SCHEDULE[r-1], else 1.
//      - decrypt: right by shift(16-n).
//    - Decrypt rotation sequence: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//    - On handshake with o_round = 15: next cycle IDLE, with o_valid=0, o_busy=0, o_last=0, o_round=0.
//      o_round_key holds its last value.
//  - i_start during RUN is ignored; i_key and i_decrypt are not sampled.
//  - i_start in the same cycle as the final handshake is ignored (not queued); restart requires IDLE.
//    Back-to-back sequences therefore have exactly one idle cycle between them.
//  - Throughput: 16 keys in 16 cycles when i_ready is held high. Total rotation over a sequence is 28 (identity).
//  - o_valid never drops without a handshake except on reset.
//  - o_last = o_valid && (o_round == 15).
// TESTING
//  - FIPS key 133457799BBCDFF1, PC-1 gives C0=1111000011001100101010101111 and D0=0101010101100110011110001111.
//    Encrypt, i_ready=1: round 0 = C1 1110000110011001010101011111, D1 1010101011001100111100011110.
//    Round 15 = C0D0, o_last=1. o_busy spans 16 cycles.
//  - Same key, decrypt: round 0 key = C0D0; round 1 = C0D0 rotated right 1. Each round n key equals encrypt
//    round 15-n key (bench compares against the stored encrypt trace).
//  - i_ready toggled pseudo-randomly: o_round_key/o_round are stable during every stall; all 16 keys are
//    emitted in order with no duplicates or skips.
//  - i_start pulsed at o_round=5 with a different key: it is ignored and the sequence completes with the
//    original key. i_start in the final handshake cycle produces no new sequence.
//  - i_rst asserted at o_round=7 under stall: the next cycle shows o_valid=0, o_busy=0, o_round=0 and
//    o_round_key=0. A fresh start then reproduces the first test's round 0 value.
//  - i_key=56'h0000001_0000001 (bit 0 of each half set), encrypt: the 1 walks through the halves according to
//    SHIFT_SCHEDULE; round 0 has bits 27 and 55 set, round 1 has bits 26 and 54 set; the value never crosses
//    between the halves.

Source files
------------

// File: rtl/des_key_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : des_key_shift_scheduler
// Description : Sequential DES key-schedule shifter. Loads a 56-bit post-PC-1
//               key, splits it into 28-bit halves C/D and emits the 16
//               per-round rotated keys C_r||D_r, one per ready/valid handshake,
//               in encrypt (K1..K16) or decrypt (K16..K1) order.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_shift_scheduler #(
    parameter logic [15:0] SHIFT_SCHEDULE = 16'h7EFC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [55:0] i_key,
    input  logic        i_decrypt,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [55:0] o_round_key,
    output logic [3:0]  o_round,
    output logic        o_last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic [3:0]  r_round;
    logic [3:0]  w_round_next;
    logic        r_decrypt;
    logic        w_decrypt_next;
    logic [3:0]  w_enc_idx;
    logic [3:0]  w_dec_idx;
    logic        w_two;

    // DES bit 1 sits at index 0, so a DES left rotate moves bit 0 up to bit 27.
    function automatic logic [27:0] rotl1(input logic [27:0] h);
        return {h[0], h[27:1]};
    endfunction

    function automatic logic [27:0] rotr1(input logic [27:0] h);
        return {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] rot_half(input logic [27:0] h,
                                             input logic        right,
                                             input logic        two);
        logic [27:0] t;
        t = right ? rotr1(h) : rotl1(h);
        if (two) begin
            t = right ? rotr1(t) : rotl1(t);
        end
        return t;
    endfunction

    // Schedule index for the step after round n: encrypt uses shift(n+2),
    // decrypt undoes shift(16-n); both map to a bit of SHIFT_SCHEDULE.
    assign w_enc_idx = r_round + 4'd1;
    assign w_dec_idx = 4'd15 - r_round;
    assign w_two     = r_decrypt ? SHIFT_SCHEDULE[w_dec_idx] : SHIFT_SCHEDULE[w_enc_idx];

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_c       <= 28'd0;
            r_d       <= 28'd0;
            r_round   <= 4'd0;
            r_decrypt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_c       <= w_c_next;
            r_d       <= w_d_next;
            r_round   <= w_round_next;
            r_decrypt <= w_decrypt_next;
        end
    end

    // Next-state and next-key logic; everything holds unless a load or handshake occurs.
    always_comb begin
        w_state_next   = r_state;
        w_c_next       = r_c;
        w_d_next       = r_d;
        w_round_next   = r_round;
        w_decrypt_next = r_decrypt;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next   = ST_RUN;
                    w_decrypt_next = i_decrypt;
                    w_round_next   = 4'd0;
                    if (i_decrypt) begin
                        // C16D16 equals C0D0, so decrypt starts unrotated.
                        w_c_next = i_key[27:0];
                        w_d_next = i_key[55:28];
                    end else begin
                        w_c_next = rot_half(i_key[27:0],  1'b0, SHIFT_SCHEDULE[0]);
                        w_d_next = rot_half(i_key[55:28], 1'b0, SHIFT_SCHEDULE[0]);
                    end
                end
            end
            ST_RUN: begin
                if (i_ready) begin
                    if (r_round == 4'd15) begin
                        // Final key keeps its value on the bus after the sequence.
                        w_state_next = ST_IDLE;
                        w_round_next = 4'd0;
                    end else begin
                        w_round_next = r_round + 4'd1;
                        w_c_next     = rot_half(r_c, r_decrypt, w_two);
                        w_d_next     = rot_half(r_d, r_decrypt, w_two);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_valid     = (r_state == ST_RUN);
    assign o_busy      = (r_state == ST_RUN);
    assign o_last      = (r_state == ST_RUN) && (r_round == 4'd15);
    assign o_round     = r_round;
    assign o_round_key = {r_d, r_c};

endmodule
`default_nettype wire

// File: tb/tb_des_key_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_shift_scheduler
// Description : Scoreboard bench for des_key_shift_scheduler with a
//               cumulative-rotation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_shift_scheduler;

    localparam logic [15:0] SCHED = 16'h7EFC;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [55:0] i_key;
    logic        i_decrypt;
    logic        i_ready;
    logic        o_busy;
    logic        o_valid;
    logic [55:0] o_round_key;
    logic [3:0]  o_round;
    logic        o_last;

    des_key_shift_scheduler #(.SHIFT_SCHEDULE(SCHED)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_key       (i_key),
        .i_decrypt   (i_decrypt),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_round_key (o_round_key),
        .o_round     (o_round),
        .o_last      (o_last)
    );

    typedef struct {
        logic [55:0] key;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          seq_done = 0;
    int          busy_cnt = 0;
    logic [55:0] trace[16];
    logic [55:0] fips_enc[16];
    logic        rst_q = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= i_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int shift_amt(input int r);
        return SCHED[r-1] ? 2 : 1;
    endfunction

    // Left rotate in DES order: out[k] = h[(k+s) mod 28].
    function automatic logic [27:0] rotl(input logic [27:0] h, input int s);
        logic [27:0] o;
        for (int k = 0; k < 28; k++) o[k] = h[(k + s) % 28];
        return o;
    endfunction

    function automatic logic [55:0] model_key(input logic [55:0] k, input bit dec, input int n);
        int s;
        int left;
        s = 0;
        if (!dec) begin
            for (int r = 1; r <= n + 1; r++) s += shift_amt(r);
            left = s % 28;
        end else begin
            for (int j = 0; j < n; j++) s += shift_amt(16 - j);
            left = (28 - (s % 28)) % 28;
        end
        return {rotl(k[55:28], left), rotl(k[27:0], left)};
    endfunction

    function automatic logic [27:0] rev28(input logic [27:0] v);
        logic [27:0] o;
        for (int k = 0; k < 28; k++) o[k] = v[27-k];
        return o;
    endfunction

    function automatic logic [55:0] rand56();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[55:0];
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic        stall_prev = 1'b0;
    logic [55:0] held_key;
    logic [3:0]  held_round;
    logic        expect_idle = 1'b0;
    logic [55:0] last_key;
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            stall_prev  = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (o_busy) busy_cnt++;
            if (stall_prev) begin
                chk("valid_held", 64'(o_valid), 64'd1);
                chk("stall_key", 64'(o_round_key), 64'(held_key));
                chk("stall_round", 64'(o_round), 64'(held_round));
            end
            chk("busy_eq_valid", 64'(o_busy), 64'(o_valid));
            chk("last_flag", 64'(o_last), 64'(o_valid && (o_round == 4'd15)));
            if (expect_idle) begin
                chk("idle_valid", 64'(o_valid), 64'd0);
                chk("idle_round", 64'(o_round), 64'd0);
                chk("idle_key_hold", 64'(o_round_key), 64'(last_key));
                expect_idle = 1'b0;
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=round%0d required=none", o_round);
                end else begin
                    e = sb_q.pop_front();
                    chk("round_key", 64'(o_round_key), 64'(e.key));
                    chk("round_idx", 64'(o_round), 64'(e.round));
                    chk("last", 64'(o_last), 64'(e.last));
                    trace[o_round] = o_round_key;
                    if (e.last) begin
                        expect_idle = 1'b1;
                        last_key    = o_round_key;
                        seq_done++;
                    end
                end
            end
            stall_prev = o_valid && !i_ready;
            held_key   = o_round_key;
            held_round = o_round;
        end
    end

    // mode 0: ready high; 1: random ready; 2: random ready + start at round 5;
    // 3: ready high + start in final handshake; 4: random ready, reset at round 7 under stall.
    task automatic run_seq(input logic [55:0] key, input bit dec, input int mode);
        int  start_done;
        int  cycles;
        int  b0;
        bit  pulsed;
        exp_t e;
        for (int n = 0; n < 16; n++) trace[n] = 56'd0;
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_key     = key;
        i_decrypt = dec;
        i_ready   = (mode == 0 || mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int n = 0; n < 16; n++) begin
            e.key   = model_key(key, dec, n);
            e.round = 4'(n);
            e.last  = (n == 15);
            sb_q.push_back(e);
        end
        start_done = seq_done;
        b0 = busy_cnt;
        pulsed = 1'b0;
        cycles = 0;
        @(posedge clk); #1;
        while (seq_done == start_done && cycles < 300) begin
            i_start   = 1'b0;
            i_key     = rand56();
            i_decrypt = 1'($urandom_range(0, 1));
            i_ready   = (mode == 0 || mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 2 && o_round == 4'd5 && !pulsed) begin
                i_start = 1'b1;
                pulsed  = 1'b1;
            end
            if (mode == 3 && o_round == 4'd15) begin
                i_start = 1'b1;
            end
            if (mode == 4 && o_round == 4'd7) begin
                i_ready = 1'b0;
                i_rst   = 1'b1;
                sb_q.delete();
                @(posedge clk); #1;
                i_rst = 1'b0;
                @(negedge clk);
                chk("rst_valid", 64'(o_valid), 64'd0);
                chk("rst_busy", 64'(o_busy), 64'd0);
                chk("rst_round", 64'(o_round), 64'd0);
                chk("rst_key", 64'(o_round_key), 64'd0);
                chk("rst_last", 64'(o_last), 64'd0);
                return;
            end
            @(posedge clk); #1;
            cycles++;
        end
        i_start = 1'b0;
        if (seq_done == start_done) begin
            checks++;
            failures++;
            $display("FAIL seq_timeout actual=%0d_cycles required=completion", cycles);
        end
        if (mode == 0) chk("busy_span", 64'(busy_cnt - b0), 64'd16);
        if (mode == 3) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_restart", 64'(o_valid), 64'd0);
            end
        end
    endtask

    initial begin
        logic [55:0] fips_key;
        logic [55:0] fips_r0;
        logic [55:0] walk;
        fips_key = {rev28(28'b0101010101100110011110001111), rev28(28'b1111000011001100101010101111)};
        fips_r0  = {rev28(28'b1010101011001100111100011110), rev28(28'b1110000110011001010101011111)};
        i_rst = 1'b1; i_start = 1'b0; i_key = 56'd0; i_decrypt = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_key", 64'(o_round_key), 64'd0);
        chk("reset_round", 64'(o_round), 64'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        run_seq(fips_key, 1'b0, 0);
        chk("fips_round0", 64'(trace[0]), 64'(fips_r0));
        chk("fips_round15", 64'(trace[15]), 64'(fips_key));
        for (int n = 0; n < 16; n++) fips_enc[n] = trace[n];

        run_seq(fips_key, 1'b1, 0);
        for (int n = 0; n < 16; n++) chk("dec_vs_enc", 64'(trace[n]), 64'(fips_enc[15-n]));

        for (int i = 0; i < 6; i++) run_seq(rand56(), 1'($urandom_range(0, 1)), 1);
        run_seq(rand56(), 1'b0, 2);
        run_seq(rand56(), 1'b1, 2);
        run_seq(rand56(), 1'b0, 3);
        run_seq(rand56(), 1'b1, 3);

        run_seq(fips_key, 1'b0, 4);
        run_seq(fips_key, 1'b0, 0);
        chk("post_rst_round0", 64'(trace[0]), 64'(fips_enc[0]));

        walk = 56'h00000010000001;
        run_seq(walk, 1'b0, 0);
        chk("walk_round0", 64'(trace[0]), 64'((56'd1 << 55) | (56'd1 << 27)));
        chk("walk_round1", 64'(trace[1]), 64'((56'd1 << 54) | (56'd1 << 26)));

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
